// File: rtl/pipe_pkg.sv
// Shared widths, control-field layout and bubble encoding for the
// core's inter-stage registers.
package pipe_pkg;

  localparam int IF_ID_CTRL_W  = 4;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 8;
  localparam int ID_EX_DATA_W  = 64;
  localparam int EX_MEM_CTRL_W = 6;
  localparam int EX_MEM_DATA_W = 64;
  localparam int MEM_WB_CTRL_W = 4;
  localparam int MEM_WB_DATA_W = 64;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_RES_SRC_LO = 2;
  localparam int CTRL_RES_SRC_HI = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JUMP       = 5;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_MEM_READ   = 7;

  localparam int BUBBLE_W = 64;
  localparam logic [BUBBLE_W-1:0] BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+ctrl+data holding register for a pipeline stage.
// Priority: kill > load > drain; ctrl reads as bubble when not valid.
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 64,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              load,
  input  logic              drain,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              vld,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  localparam logic [CTRL_W-1:0] BUBBLE = CTRL_W'(BUBBLE_CTRL);

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (kill) begin
      vld_d  = 1'b0;
      ctrl_d = BUBBLE;
      if (CLEAR_DATA) data_d = '0;
    end else if (load) begin
      vld_d  = 1'b1;
      ctrl_d = ld_ctrl;
      data_d = ld_data;
    end else if (drain) begin
      // data left in place to avoid toggling the datapath
      vld_d  = 1'b0;
      ctrl_d = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      ctrl_q <= BUBBLE;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign vld  = vld_q;
  assign ctrl = ctrl_q;
  assign data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with valid/ready, stall, flush and
// a saturating flush counter. PIPE_STAGE_SKID_EN adds a skid entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = ID_EX_CTRL_W,
  parameter int DATA_W     = ID_EX_DATA_W,
  parameter bit CLEAR_DATA = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              main_vld;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_drain;
  logic [CTRL_W-1:0] main_src_ctrl;
  logic [DATA_W-1:0] main_src_data;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        kill_cnt;

  assign out_fire = main_vld & out_ready & ~stall_i;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_vld;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              skid_load;
  logic              skid_drain;

  assign in_ready = ~skid_vld;
  assign in_fire  = in_valid & in_ready;

  // skid is older than any new beat, so it refills main first
  assign main_load  = ~flush_i & (out_fire | ~main_vld)
                    & (skid_vld | in_fire);
  assign main_drain = out_fire & ~skid_vld & ~in_fire;
  assign main_src_ctrl = skid_vld ? skid_ctrl : in_ctrl;
  assign main_src_data = skid_vld ? skid_data : in_data;

  assign skid_load  = ~flush_i & main_vld & ~out_fire & in_fire;
  assign skid_drain = out_fire & skid_vld;

  assign kill_cnt = {1'b0, main_vld} + {1'b0, skid_vld};

  pipe_stage_entry #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush_i),
    .load    (skid_load),
    .drain   (skid_drain),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .vld     (skid_vld),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  // flush accepts and drops whatever is offered this cycle
  assign in_ready = ~main_vld | (out_ready & ~stall_i) | flush_i;
  assign in_fire  = in_valid & in_ready;

  assign main_load     = ~flush_i & in_fire;
  assign main_drain    = out_fire & ~in_fire;
  assign main_src_ctrl = in_ctrl;
  assign main_src_data = in_data;

  assign kill_cnt = {1'b0, main_vld};
`endif

  pipe_stage_entry #(
    .CTRL_W     (CTRL_W),
    .DATA_W     (DATA_W),
    .CLEAR_DATA (CLEAR_DATA)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .kill    (flush_i),
    .load    (main_load),
    .drain   (main_drain),
    .ld_ctrl (main_src_ctrl),
    .ld_data (main_src_data),
    .vld     (main_vld),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  assign out_valid = main_vld;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(kill_cnt);
    cnt_d   = cnt_q;
    if (flush_i) begin
      cnt_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign flush_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Random + directed bench for pipe_stage_reg against a queue model.
// Instance a: CLEAR_DATA=0, CNT_W=16; instance b: CLEAR_DATA=1, CNT_W=3.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;

  logic        a_ready, a_valid, b_ready, b_valid;
  logic [7:0]  a_ctrl, b_ctrl;
  logic [63:0] a_data, b_data;
  logic [15:0] a_cnt;
  logic [2:0]  b_cnt;

  pipe_stage_reg #(
    .CTRL_W(8), .DATA_W(64), .CLEAR_DATA(1'b0), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .in_valid(in_valid), .in_ready(a_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(a_valid), .out_ready(out_ready),
    .out_ctrl(a_ctrl), .out_data(a_data), .flush_cnt(a_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W(8), .DATA_W(64), .CLEAR_DATA(1'b1), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .flush_i(flush_i), .stall_i(stall_i),
    .in_valid(in_valid), .in_ready(b_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(b_valid), .out_ready(out_ready),
    .out_ctrl(b_ctrl), .out_data(b_data), .flush_cnt(b_cnt)
  );

  typedef struct {
    logic [7:0]  c;
    logic [63:0] d;
  } beat_t;

  beat_t       q[$];
  int unsigned m_cnt = 0;
  logic [63:0] la = '0;
  logic [63:0] lb = '0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit exp_ready();
    if (SKID) return q.size() < 2;
    return q.size() == 0 || (out_ready && !stall_i) || flush_i;
  endfunction

  task automatic model_update();
    bit    rdy, ofire, ifire;
    beat_t b;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      la = '0;
      lb = '0;
      return;
    end
    rdy   = exp_ready();
    ofire = q.size() > 0 && out_ready && !stall_i;
    ifire = in_valid && rdy;
    if (flush_i) begin
      m_cnt += q.size();
      q.delete();
      lb = '0;
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        b.c = in_ctrl;
        b.d = in_data;
        q.push_back(b);
      end
    end
    if (q.size() > 0) begin
      la = q[0].d;
      lb = q[0].d;
    end
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic compare();
    logic        ev;
    logic [7:0]  ec;
    logic [63:0] ca, cb;
    ev = q.size() > 0;
    ec = ev ? q[0].c : 8'h00;
    ca = (m_cnt > 65535) ? 64'd65535 : 64'(m_cnt);
    cb = (m_cnt > 7) ? 64'd7 : 64'(m_cnt);
    check("a_valid", a_valid, ev);
    check("b_valid", b_valid, ev);
    check("a_ctrl", a_ctrl, ec);
    check("b_ctrl", b_ctrl, ec);
    check("a_data", a_data, la);
    check("b_data", b_data, lb);
    check("a_cnt", a_cnt, ca);
    check("b_cnt", b_cnt, cb);
    check("a_ready", a_ready, exp_ready());
    check("b_ready", b_ready, exp_ready());
  endtask

  task automatic step(input logic r, input logic f, input logic s,
                      input logic v, input logic [7:0] c,
                      input logic [63:0] d, input logic o);
    @(posedge clk);
    model_update();
    #1;
    rst = r;
    flush_i = f;
    stall_i = s;
    in_valid = v;
    in_ctrl = c;
    in_data = d;
    out_ready = o;
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input logic o);
    step(0, 0, 0, 0, 8'h00, 64'h0, o);
  endtask

  initial begin
    step(1, 0, 0, 1, 8'h77, 64'h77, 1);
    step(1, 0, 0, 1, 8'h77, 64'h77, 1);
    check("rst_valid", a_valid, 0);
    check("rst_ctrl", a_ctrl, 0);
    check("rst_cnt", a_cnt, 0);
    check("rst_data", a_data, 0);
    idle(1);

    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 1, 8'(i), 64'(i) << 8, 1);
      if (i > 1) check("stream", a_ctrl, 64'(i - 1));
    end
    idle(1);
    check("stream_last", a_ctrl, 8'h04);
    idle(1);
    check("stream_empty", a_valid, 0);

    step(0, 0, 0, 1, 8'hA5, 64'hA5A5, 1);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 1, 8'h5A, 64'h5A5A, 1);
      check("stall_hold", a_ctrl, 8'hA5);
`ifndef PIPE_STAGE_SKID_EN
      check("stall_rdy", a_ready, 0);
`endif
    end
    step(0, 0, 0, 1, 8'h5A, 64'h5A5A, 1);
    check("stall_rel", a_ctrl, 8'hA5);
    idle(1);
    check("stall_next", a_ctrl, 8'h5A);

    step(0, 0, 0, 1, 8'h33, 64'hD000_0000_0000_0033, 0);
    step(0, 1, 0, 1, 8'h44, 64'h44, 0);
    check("flush_rdy", a_ready, 1);
    check("flush_pre", a_ctrl, 8'h33);
    idle(1);
    check("flush_valid", a_valid, 0);
    check("flush_ctrl", a_ctrl, 0);
    check("flush_cnt_a", a_cnt, 1);
    check("flush_cnt_b", b_cnt, 1);
    check("flush_data_a", a_data, 64'hD000_0000_0000_0033);
    check("flush_data_b", b_data, 0);
    step(0, 1, 0, 0, 8'h00, 64'h0, 1);
    idle(1);
    check("flush_empty", a_cnt, 1);

`ifdef PIPE_STAGE_SKID_EN
    step(0, 0, 0, 1, 8'h01, 64'h1, 0);
    step(0, 0, 0, 1, 8'h02, 64'h2, 0);
    idle(0);
    check("skid_rdy", a_ready, 0);
    check("skid_o1", a_ctrl, 8'h01);
    idle(1);
    check("skid_o1b", a_ctrl, 8'h01);
    idle(1);
    check("skid_o2", a_ctrl, 8'h02);
    step(0, 0, 0, 1, 8'h01, 64'h1, 0);
    step(0, 0, 0, 1, 8'h02, 64'h2, 0);
    idle(0);
    step(0, 1, 0, 0, 8'h00, 64'h0, 0);
    idle(1);
    check("skid_flush2", a_cnt, 3);
`endif

    for (int n = 0; n < 3000; n++) begin
      step((n < 2500) && ($urandom_range(0, 199) == 0),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0,
           8'($urandom),
           {$urandom, $urandom},
           $urandom_range(0, 3) != 0);
    end
    idle(1);
    check("sat_b", b_cnt, 3'h7);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
